// File: rtl/bus_gnrtr_arbiter.sv
// Shared-bus generator: per bus, a round-robin arbiter pops one packet from a pending
// device FIFO and pushes it to the device(s) named by the packet's 8-bit ID field.
module bus_gnrtr_arbiter #(
  parameter int         bits      = 1,
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 16,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [bits*drvrs-1:0]          pndng,
  input  logic [bits*drvrs*pckg_sz-1:0]  D_pop,
  output logic [bits*drvrs-1:0]          pop,
  output logic [bits*drvrs-1:0]          push,
  output logic [bits*drvrs*pckg_sz-1:0]  D_push
);

  localparam int PW = (drvrs > 1) ? $clog2(drvrs) : 1;

  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

  // First pending device at or after ptr, wrapping modulo drvrs.
  function automatic logic [PW-1:0] pick(input logic [drvrs-1:0] pnd, input logic [PW-1:0] ptr);
    logic [PW-1:0] idx;
    pick = ptr;
    for (int k = drvrs - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % drvrs);
      if (pnd[idx]) pick = idx;
    end
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] g);
    next_ptr = (int'(g) == drvrs - 1) ? '0 : g + PW'(1);
  endfunction

  for (genvar b = 0; b < bits; b++) begin : g_bus
    state_t              state, state_nxt;
    logic [PW-1:0]       ptr, grant;
    logic [pckg_sz-1:0]  pkt;
    logic [pckg_sz-1:0]  heads [drvrs];
    logic [drvrs-1:0]    pnd_bus, pop_bus, push_bus, src_onehot;
    logic [7:0]          id;

    assign pnd_bus = pndng[b*drvrs +: drvrs];
    assign id      = pkt[pckg_sz-1 -: 8];

    for (genvar d = 0; d < drvrs; d++) begin : g_dev
      assign heads[d] = D_pop[(b*drvrs+d)*pckg_sz +: pckg_sz];
      assign D_push[(b*drvrs+d)*pckg_sz +: pckg_sz] = pkt;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state <= IDLE;
        ptr   <= '0;
        grant <= '0;
        pkt   <= '0;
      end else begin
        state <= state_nxt;
        if (state == IDLE && |pnd_bus) grant <= pick(pnd_bus, ptr);
        if (state == POP) begin
          pkt <= heads[grant];
          ptr <= next_ptr(grant);
        end
      end
    end

    always_comb begin
      state_nxt = state;
      case (state)
        IDLE:    if (|pnd_bus) state_nxt = POP;
        POP:     state_nxt = PUSH;
        PUSH:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    // Grant is stable through PUSH, so it still identifies the source for broadcast.
    always_comb begin
      pop_bus    = '0;
      push_bus   = '0;
      src_onehot = '0;
      src_onehot[grant] = 1'b1;
      if (state == POP) pop_bus = src_onehot;
      if (state == PUSH) begin
        if (id == broadcast)        push_bus = ~src_onehot;
        else if (int'(id) < drvrs)  push_bus[id[PW-1:0]] = 1'b1;
      end
    end

    assign pop[b*drvrs +: drvrs]  = pop_bus;
    assign push[b*drvrs +: drvrs] = push_bus;
  end

endmodule

// File: tb/tb_bus_gnrtr_arbiter.sv
// Directed bench for bus_gnrtr_arbiter with one bus of four devices and 16-bit packets.
module tb_bus_gnrtr_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  pndng;
  logic [63:0] d_pop;
  logic [3:0]  pop, push;
  logic [63:0] d_push;

  int n_vec = 0;
  int n_bad = 0;

  bus_gnrtr_arbiter #(.bits(1), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop),
    .pop(pop), .push(push), .D_push(d_push)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_head(input int d, input logic [15:0] v);
    d_pop[d*16 +: 16] = v;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_pop"}, 64'(pop), 64'h0);
    chk({tag, "_push"}, 64'(push), 64'h0);
  endtask

  initial begin
    reset = 1'b1;
    pndng = 4'b1111;
    d_pop = {16'h0333, 16'h0322, 16'h0311, 16'h0300};

    // Reset held with every device pending: all outputs stay quiet.
    for (int i = 0; i < 5; i++) begin
      step();
      chk_idle("rst_hold");
      chk("rst_dpush", d_push, 64'h0);
    end
    step();
    reset = 1'b0;
    step();
    chk("first_pop", 64'(pop), 64'h1);
    chk("first_pop_push", 64'(push), 64'h0);
    step();
    chk("first_push", 64'(push), 64'h8);
    chk("first_dpush", d_push, {4{16'h0300}});
    chk("first_push_pop", 64'(pop), 64'h0);
    pndng = 4'b0000;
    step();
    chk_idle("first_idle");

    // Unicast from device 1 to device 2 (pointer is now 1).
    set_head(1, 16'h0212);
    pndng = 4'b0010;
    step();
    chk("uni_pop", 64'(pop), 64'h2);
    step();
    chk("uni_push", 64'(push), 64'h4);
    chk("uni_dpush", d_push, {4{16'h0212}});
    pndng = 4'b0000;
    step();
    chk_idle("uni_idle");

    // Broadcast from device 0, found by wrapping from pointer 2.
    set_head(0, 16'hFFAB);
    pndng = 4'b0001;
    step();
    chk("bc_pop", 64'(pop), 64'h1);
    step();
    chk("bc_push", 64'(push), 64'hE);
    chk("bc_dpush", d_push, {4{16'hFFAB}});
    pndng = 4'b0000;
    step();
    chk_idle("bc_idle");

    // Pointer back to 0 via reset, then all-to-one traffic into device 3.
    reset = 1'b1;
    step();
    reset = 1'b0;
    d_pop = {16'h03A3, 16'h03A2, 16'h03A1, 16'h03A0};
    pndng = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      int g;
      logic [15:0] p;
      g = i % 4;
      p = 16'h03A0 + 16'(g);
      step();
      chk($sformatf("rr%0d_pop", i), 64'(pop), 64'(4'b0001 << g));
      step();
      chk($sformatf("rr%0d_push", i), 64'(push), 64'h8);
      chk($sformatf("rr%0d_dpush", i), d_push, {4{p}});
      step();
      chk_idle($sformatf("rr%0d_idle", i));
      if (i == 4) pndng = 4'b0000;
    end

    // Invalid ID from device 2: popped but dropped; pointer advances to 3.
    set_head(2, 16'h0755);
    pndng = 4'b0100;
    step();
    chk("inv_pop", 64'(pop), 64'h4);
    step();
    chk_idle("inv_drop");
    pndng = 4'b0000;
    step();
    chk_idle("inv_idle");
    set_head(3, 16'h0311);
    set_head(0, 16'h0100);
    pndng = 4'b1001;
    step();
    chk("inv_next_pop", 64'(pop), 64'h8);
    step();
    chk("inv_next_push", 64'(push), 64'h8);
    chk("inv_next_dpush", d_push, {4{16'h0311}});
    pndng = 4'b0000;
    step();
    chk_idle("inv_next_idle");

    // Reset during POP: pop drops at once, no push, restart from device 0.
    set_head(3, 16'h0200);
    pndng = 4'b1000;
    step();
    chk("arst_pop_before", 64'(pop), 64'h8);
    #1 reset = 1'b1;
    #1 chk("arst_pop_async", 64'(pop), 64'h0);
    step();
    chk("arst_push", 64'(push), 64'h0);
    chk("arst_dpush", d_push, 64'h0);
    reset = 1'b0;
    pndng = 4'b0000;
    step();
    chk_idle("arst_quiet1");
    step();
    chk_idle("arst_quiet2");
    set_head(1, 16'h0000);
    pndng = 4'b1010;
    step();
    chk("arst_restart_pop", 64'(pop), 64'h2);
    step();
    chk("arst_restart_push", 64'(push), 64'h1);
    chk("arst_restart_dpush", d_push, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
